// File: rtl/pvt_frame_packer.sv
// pvt_frame_packer: buffers 16-bit PVT samples and serialises each as a
// 5-byte frame (HEADER, SEQ, data hi, data lo, CHK) through the uart_tx start/busy handshake.
module pvt_frame_packer #(
    parameter int unsigned DEPTH  = 4,
    parameter logic [7:0]  HEADER = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_valid,
    input  logic [15:0] sample_data,
    output logic        sample_ready,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    output logic        frame_active,
    output logic        overflow
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t state, state_nxt;

    logic [15:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, empty, push, pop;

    logic [15:0] samp_q;
    logic [7:0]  chk_q;
    logic [7:0]  seq_q;
    logic [2:0]  idx_q, idx_nxt;
    logic [7:0]  byte_sel;
    logic        seq_inc;

    // Extra wrap bit on each pointer distinguishes full from empty.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign push  = sample_valid && !full;
    assign pop   = (state == LOAD);

    assign sample_ready = !full;
    assign frame_active = (state != IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= sample_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (pop) begin
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (sample_valid && full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx_q;
        seq_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                idx_nxt   = '0;
                state_nxt = SEND;
            end
            SEND: begin
                state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (tx_busy) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (idx_q == 3'd4) begin
                        seq_inc   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        idx_nxt   = idx_q + 3'd1;
                        state_nxt = SEND;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Byte for the upcoming SEND; header needs no latched data, so LOAD->SEND is safe.
    always_comb begin
        byte_sel = chk_q;
        case (idx_nxt)
            3'd0:    byte_sel = HEADER;
            3'd1:    byte_sel = seq_q;
            3'd2:    byte_sel = samp_q[15:8];
            3'd3:    byte_sel = samp_q[7:0];
            default: byte_sel = chk_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx_q    <= '0;
            seq_q    <= '0;
            samp_q   <= '0;
            chk_q    <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            state    <= state_nxt;
            idx_q    <= idx_nxt;
            tx_start <= (state_nxt == SEND);
            if (state_nxt == SEND) begin
                tx_data <= byte_sel;
            end
            if (state == LOAD) begin
                samp_q <= mem[rd_ptr[AW-1:0]];
                chk_q  <= seq_q ^ mem[rd_ptr[AW-1:0]][15:8] ^ mem[rd_ptr[AW-1:0]][7:0];
            end
            if (seq_inc) begin
                seq_q <= seq_q + 8'd1;
            end
        end
    end

endmodule

// File: doc/pvt_frame_packer.md
# pvt_frame_packer

Upstream feeder for `uart_tx`: buffers 16-bit PVT sensor samples in a small FIFO and serialises each one as a fixed 5-byte frame, issuing one `uart_tx` start per byte. It owns the start/busy handshake with `uart_tx`, so sensor logic only needs a valid/ready push interface. It sits between the sensor sample path and `uart_tx`, and its `tx_start`/`tx_data` outputs connect directly to `start`/`in_data`.

## Interface
- `DEPTH`, 4: sample FIFO entries (power of two, ≥2).
- `HEADER`, 8'hA5: first byte of every frame.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `sample_valid` in 1: the sample on `sample_data` is offered this cycle.
- `sample_data` in 16: sensor sample.
- `sample_ready` out 1: the FIFO can accept a sample (not full).
- `tx_start` out 1: one-cycle start pulse to `uart_tx`.
- `tx_data` out 8: byte to send; registered.
- `tx_busy` in 1: `uart_tx` busy.
- `frame_active` out 1: a frame is in progress (FSM not in IDLE).
- `overflow` out 1: sticky flag, set when a sample is offered while the FIFO is full.

## Operation
- **Push:** a sample is written when `sample_valid & sample_ready`.
  - `sample_ready = !full`. It stays 0 while full even if a pop happens the same cycle; there is no pass-through.
  - `sample_valid & !sample_ready` sets `overflow`. The sample is dropped, and only `rst` clears the flag.
- **Frame format:** bytes go out in order 0..4:
  - byte 0: `HEADER`
  - byte 1: `SEQ`
  - byte 2: `data[15:8]`
  - byte 3: `data[7:0]`
  - byte 4: `CHK = SEQ ^ data[15:8] ^ data[7:0]`
- **SEQ:** an 8-bit frame counter. It increments after byte 4 completes and wraps 8'hFF → 8'h00.
- **FSM states:**
  - IDLE: if the FIFO is non-empty → LOAD.
  - LOAD: pop the FIFO, latch the sample and CHK, clear the byte index → SEND.
  - SEND: `tx_data` ← byte[idx], `tx_start` = 1 for exactly this cycle → WAIT_ACK.
  - WAIT_ACK: wait for `tx_busy` = 1 → WAIT_DONE.
  - WAIT_DONE: wait for `tx_busy` = 0. Then, if idx = 4: SEQ++ → IDLE; else idx++ → SEND.
- **FIFO:** read and write pointers each have one extra wrap bit. Full/empty are derived from pointer compare. A pop and a push in the same cycle are both honoured when the FIFO is non-full and non-empty.
- **Reset:** reset mid-frame aborts the frame and flushes the FIFO, with no partial completion. A byte already handed to `uart_tx` finishes on the line independently.

## Timing
- **Reset values:**
  - `tx_start` = 0, `tx_data` = 8'h00
  - `frame_active` = 0, `overflow` = 0
  - `sample_ready` = 1, SEQ = 0
  - FIFO empty, FSM in IDLE
- **Latency:** a sample accepted at edge N (FIFO empty, FSM IDLE) gives LOAD in cycle N+1 and `tx_start` = 1 in cycle N+2, with `tx_data` = `HEADER`.
- **Start pulse:** `tx_start` is high for exactly one cycle per byte, with `tx_data` valid in that same cycle. `tx_data` holds until the next SEND.
- **Busy handshake:** `uart_tx` is required to raise `busy` in the cycle after `start`. The packer never re-pulses `tx_start` while `tx_busy` = 1, or before `busy` has been seen high for the current byte.
- **Inter-byte gap:** the next byte's `tx_start` comes 1 cycle after `tx_busy` falls (WAIT_DONE → SEND).
- **Back-to-back frames:** after byte 4 completes, a non-empty FIFO gives IDLE → LOAD → SEND. That is 3 cycles from `tx_busy` falling to the next `HEADER` start.
- **`frame_active`:** high from LOAD through the final WAIT_DONE, inclusive.

## Test plan
- **Reset check:** hold `rst` 5 cycles, then release → all outputs at reset values and no `tx_start` for 20 cycles.
- **Single sample:** push 16'h1234 with `uart_tx` model busy for 10 cycles per byte → bytes A5, 00, 12, 34, 26 in order; exactly 5 `tx_start` pulses; first pulse 2 cycles after acceptance.
- **Sequence wrap:** push 257 samples of 16'h0000 → SEQ bytes run 00..FF, 00; CHK equals SEQ in each frame.
- **Full/overflow:** hold `tx_busy` = 1 and push 6 samples → 1 popped into the frame, 4 buffered; the 6th push sees `sample_ready` = 0 and `overflow` = 1; release `busy` → 5 correct frames total; `overflow` stays 1.
- **Simultaneous push/pop:** FIFO holding 2 entries, push in the LOAD cycle → count stays 2 and no data is lost or reordered.
- **Mid-frame reset:** assert `rst` during byte 2's WAIT_DONE with 3 samples queued → FIFO empty, SEQ = 0, `tx_start` silent until a new push; the next frame starts with A5, 00.
